riscv_multicycle_controller: RTL and testbench
==============================================

Name: riscv_multicycle_controller

Overview:
- Multicycle successor to the single-cycle RV32I controller. It is a Moore FSM that sequences fetch, decode, execute, memory access and writeback over a shared ALU and a unified memory.
- Adds the full branch set, shifts, set-less-than, LUI, AUIPC and JALR, a memory-ready handshake, and an illegal-instruction flag.
- Sits between the datapath flag/instruction fields and the datapath mux/enable controls.

Parameters:
- FULL_ISA, 1: 1 = full RV32I integer set; 0 = legacy subset only (lw, sw, R/I add/sub/and/or/slt, beq, jal); all other opcodes are illegal.
- MEM_WAIT, 1: 1 = Fetch/MemRead/MemWrite hold until MemReady; 0 = MemReady ignored (treated as 1).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  7  instruction opcode (from IR)
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- Zero  in  1  ALU result == 0
- LessThan  in  1  signed rs1 < rs2
- LessThanU  in  1  unsigned rs1 < rs2
- MemReady  in  1  memory completes the access this cycle
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR/OldPC load enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = const 4
- ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 passB
- IllegalInstr  out  1  one-cycle pulse in Decode on an unsupported encoding

Behaviour:
- Reset: synchronous. While reset = 1, the state register loads FETCH and every enable (PCWrite, MemWrite, IRWrite, RegWrite) is forced to 0. The first cycle after reset deassertion is FETCH.
- Outputs: enables are a Moore function of state, except:
  - PCWrite in BRANCH is gated by the branch condition.
  - FETCH/MEMWR strobes are gated by MemReady.
  - ImmSrc is purely combinational from op.
- FETCH: AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, add, ResultSrc = 10.
  - When MemReady = 1: IRWrite = 1, PCWrite = 1, then go to DECODE.
  - Otherwise: stay in FETCH, no enables asserted.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, add (ALUOut ← OldPC + imm). Next state by op:
  - lw/sw → MEMADR
  - R-type → EXECR
  - I-ALU → EXECI
  - jal → JAL
  - jalr → EXECJALR
  - branch → BRANCH
  - lui → EXECLUI
  - auipc → EXECAUIPC
  - otherwise → FETCH with IllegalInstr = 1
- MEMADR: SrcA = 10, SrcB = 01, add. Go to MEMRD (lw) or MEMWR (sw).
- MEMRD: AdrSrc = 1. Hold until MemReady, then go to MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1, then FETCH.
- MEMWR: AdrSrc = 1, MemWrite = MemReady. Go to FETCH when MemReady.
- EXECR: SrcA = 10, SrcB = 00, ALU op from funct3/funct7b5 (sub when funct7b5 = 1 on funct3 000; sra when 1 on 101). Then ALUWB.
- EXECI: as EXECR with SrcB = 01. sub is never selected; funct7b5 selects sra on funct3 101 only. Then ALUWB.
- EXECLUI: SrcB = 01, passB, then ALUWB.
- EXECAUIPC: SrcA = 01, SrcB = 01, add, then ALUWB.
- EXECJALR: SrcA = 10, SrcB = 01, add (ALUOut ← rs1 + imm), then JAL.
- JAL: SrcA = 01, SrcB = 10, add, ResultSrc = 00, PCWrite = 1 (PC ← ALUOut), then ALUWB (writes OldPC + 4).
- ALUWB: ResultSrc = 00, RegWrite = 1, then FETCH.
- BRANCH: SrcA = 10, SrcB = 00, sub, ResultSrc = 00. PCWrite is set by funct3:
  - 000: Zero
  - 001: ~Zero
  - 100: LessThan
  - 101: ~LessThan
  - 110: LessThanU
  - 111: ~LessThanU
  - 010/011 are detected as illegal in DECODE.
  - Then FETCH.
- Cycle counts (MemReady = 1): branch 3; sw, R, I, lui, auipc 4; lw, jal 4/5 (lw 5, jal 4); jalr 5. Each wait cycle adds 1.
- Reset mid-instruction: abandon the instruction and return to FETCH next cycle. No writes occur in the reset cycle.
- Unknown funct3/funct7 in R/I: decoded as illegal in DECODE.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum
  - opcode constants
  - ALUControl, ResultSrc, ALUSrcA/B and ImmSrc encodings
- One sub-module: riscv_alu_decoder (combinational funct3/funct7b5/state-class → ALUControl, plus a legality flag).

Test Plan:
- R-type add (op 0110011, f3 000, f7b5 0), MemReady = 1 → states FETCH, DECODE, EXECR, ALUWB; ALUControl 0000 in EXECR; RegWrite = 1 only in cycle 4.
- lw with MemReady low 2 cycles in MEMRD → MEMRD held 3 cycles, RegWrite in MEMWB only; total 7 cycles.
- bne with Zero = 0 → PCWrite = 1 in BRANCH. bgeu with LessThanU = 1 → PCWrite = 0. Both instructions take 3 cycles.
- jalr → PCWrite in JAL state with ResultSrc = 00; then ALUWB with RegWrite = 1 and SrcA = 01 / SrcB = 10 visible in JAL.
- FULL_ISA = 0, op = lui (0110111) → IllegalInstr pulses 1 cycle in DECODE, no enables, next state FETCH.
- reset asserted in MEMWR with MemReady = 1 → MemWrite = 0 that cycle; FETCH the next cycle.

Source files
------------

// File: rtl/riscv_multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I controller:
// FSM states, opcodes and datapath mux/ALU select codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
    S_EXECI, S_EXECLUI, S_EXECAUIPC, S_EXECJALR, S_JAL, S_ALUWB, S_BRANCH
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR = 4'b0011,
    ALU_XOR = 4'b0100, ALU_SLT = 4'b0101, ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111,
    ALU_SRL = 4'b1000, ALU_SRA = 4'b1001, ALU_PASSB = 4'b1010
  } alu_ctrl_t;

  // Which flavour of ALU operation the current state asks for.
  typedef enum logic [2:0] {
    ACLS_ADD, ACLS_SUB, ACLS_PASSB, ACLS_FUNCT_R, ACLS_FUNCT_I
  } alu_class_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/riscv_multicycle_controller_if.sv
// Controller <-> datapath signal bundle: instruction fields and flags in,
// mux selects and write enables out.
interface riscv_multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       LessThan;
  logic       LessThanU;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       IllegalInstr;

  modport master (
    input  op, funct3, funct7b5, Zero, LessThan, LessThanU, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr
  );

  modport slave (
    output op, funct3, funct7b5, Zero, LessThan, LessThanU, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr
  );
endinterface

// File: rtl/riscv_multicycle_controller_alu_decoder.sv
// ALU operation select from funct3/funct7b5 and the state's operation class,
// plus legality of an R/I-type funct3/funct7b5 combination.
module riscv_alu_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter bit FULL_ISA = 1'b1
) (
  input  alu_class_t alu_class,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       rtype,
  output logic [3:0] alu_control,
  output logic       legal
);

  logic legacy_f3;

  always_comb begin
    alu_control = ALU_ADD;
    unique case (alu_class)
      ACLS_SUB:   alu_control = ALU_SUB;
      ACLS_PASSB: alu_control = ALU_PASSB;
      ACLS_FUNCT_R, ACLS_FUNCT_I: begin
        unique case (funct3)
          3'b000: alu_control = (alu_class == ACLS_FUNCT_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control = ALU_SLL;
          3'b010: alu_control = ALU_SLT;
          3'b011: alu_control = ALU_SLTU;
          3'b100: alu_control = ALU_XOR;
          3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  // In I-type, funct7b5 is an immediate bit except for the shift encodings.
  always_comb begin
    legacy_f3 = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                (funct3 == 3'b110) || (funct3 == 3'b111);
    if (FULL_ISA) begin
      legal = rtype ? (!funct7b5 || funct3 == 3'b000 || funct3 == 3'b101)
                    : !(funct3 == 3'b001 && funct7b5);
    end else begin
      legal = rtype ? (legacy_f3 && (!funct7b5 || funct3 == 3'b000)) : legacy_f3;
    end
  end

endmodule

// File: rtl/riscv_multicycle_controller.sv
// Moore FSM sequencing fetch/decode/execute/memory/writeback for a multicycle
// RV32I datapath with a shared ALU and unified memory.
module riscv_multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit FULL_ISA = 1'b1,
  parameter bit MEM_WAIT = 1'b1
) (
  input logic                          clk,
  input logic                          reset,
  riscv_multicycle_controller_if.master bus
);

  state_t     state, next_state;
  alu_class_t alu_class;
  logic       mem_ready, op_legal, funct_legal, branch_taken;
  logic       pc_write, mem_write, ir_write, reg_write, illegal;

  assign mem_ready = bus.MemReady | ~MEM_WAIT;

  riscv_alu_decoder #(.FULL_ISA(FULL_ISA)) u_alu_dec (
    .alu_class  (alu_class),
    .funct3     (bus.funct3),
    .funct7b5   (bus.funct7b5),
    .rtype      (bus.op == OP_R),
    .alu_control(bus.ALUControl),
    .legal      (funct_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    unique case (bus.op)
      OP_LOAD, OP_STORE, OP_JAL: op_legal = 1'b1;
      OP_R, OP_I:                op_legal = funct_legal;
      OP_BRANCH: op_legal = FULL_ISA ? (bus.funct3[2:1] != 2'b01) : (bus.funct3 == 3'b000);
      OP_JALR, OP_LUI, OP_AUIPC: op_legal = FULL_ISA;
      default:                   op_legal = 1'b0;
    endcase
  end

  always_comb begin
    unique case (bus.funct3)
      3'b000:  branch_taken = bus.Zero;
      3'b001:  branch_taken = ~bus.Zero;
      3'b100:  branch_taken = bus.LessThan;
      3'b101:  branch_taken = ~bus.LessThan;
      3'b110:  branch_taken = bus.LessThanU;
      3'b111:  branch_taken = ~bus.LessThanU;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    unique case (bus.op)
      OP_STORE:          bus.ImmSrc = IMM_S;
      OP_BRANCH:         bus.ImmSrc = IMM_B;
      OP_JAL:            bus.ImmSrc = IMM_J;
      OP_LUI, OP_AUIPC:  bus.ImmSrc = IMM_U;
      default:           bus.ImmSrc = IMM_I;
    endcase
  end

  always_comb begin
    next_state    = state;
    pc_write      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    illegal       = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ResultSrc = RES_ALUOUT;
    bus.ALUSrcA   = SRCA_PC;
    bus.ALUSrcB   = SRCB_RD2;
    alu_class     = ACLS_ADD;
    unique case (state)
      S_FETCH: begin
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        if (!op_legal) begin
          illegal    = 1'b1;
          next_state = S_FETCH;
        end else begin
          unique case (bus.op)
            OP_LOAD, OP_STORE: next_state = S_MEMADR;
            OP_R:              next_state = S_EXECR;
            OP_I:              next_state = S_EXECI;
            OP_JAL:            next_state = S_JAL;
            OP_JALR:           next_state = S_EXECJALR;
            OP_BRANCH:         next_state = S_BRANCH;
            OP_LUI:            next_state = S_EXECLUI;
            OP_AUIPC:          next_state = S_EXECAUIPC;
            default:           next_state = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
        next_state  = (bus.op == OP_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.AdrSrc = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_DATA;
        reg_write     = 1'b1;
        next_state    = S_FETCH;
      end
      S_MEMWR: begin
        bus.AdrSrc = 1'b1;
        mem_write  = mem_ready;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXECR: begin
        bus.ALUSrcA = SRCA_RD1;
        alu_class   = ACLS_FUNCT_R;
        next_state  = S_ALUWB;
      end
      S_EXECI: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
        alu_class   = ACLS_FUNCT_I;
        next_state  = S_ALUWB;
      end
      S_EXECLUI: begin
        bus.ALUSrcB = SRCB_IMM;
        alu_class   = ACLS_PASSB;
        next_state  = S_ALUWB;
      end
      S_EXECAUIPC: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        next_state  = S_ALUWB;
      end
      S_EXECJALR: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
        next_state  = S_JAL;
      end
      // PC takes the target latched in ALUOut while the ALU forms the link value.
      S_JAL: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        pc_write    = 1'b1;
        next_state  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA = SRCA_RD1;
        alu_class   = ACLS_SUB;
        pc_write    = branch_taken;
        next_state  = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

  assign bus.PCWrite      = pc_write  & ~reset;
  assign bus.MemWrite     = mem_write & ~reset;
  assign bus.IRWrite      = ir_write  & ~reset;
  assign bus.RegWrite     = reg_write & ~reset;
  assign bus.IllegalInstr = illegal   & ~reset;

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Randomised instruction-level bench for the multicycle controller; a per-step
// expectation model built from instruction class is checked every cycle.
module tb_riscv_multicycle_controller;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011,
                         ITYPE = 7'b0010011, JAL = 7'b1101111, JALR = 7'b1100111,
                         BRANCH = 7'b1100011, LUI = 7'b0110111, AUIPC = 7'b0010111;

  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5, P_XR = 6,
                 P_XI = 7, P_LUI = 8, P_AUI = 9, P_JALR = 10, P_JAL = 11, P_WB = 12,
                 P_BR = 13, P_RST = 14;

  typedef struct {
    logic       pcw, adr, memw, irw, regw, ill;
    logic [1:0] rs, sa, sb;
    logic [3:0] alu;
    logic [2:0] imm;
    bit         c_adr, c_rs, c_sa, c_sb, c_alu;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0, Zero = 1'b0, LessThan = 1'b0, LessThanU = 1'b0;
  logic       MemReady = 1'b0;
  bit         chk_en = 1'b0;
  bit         sel = 1'b0;
  exp_t       cur;
  int         tests = 0, fails = 0;

  always #5 clk = ~clk;

  riscv_multicycle_controller_if bf ();
  riscv_multicycle_controller_if bl ();

  assign bf.op = op;             assign bl.op = op;
  assign bf.funct3 = funct3;     assign bl.funct3 = funct3;
  assign bf.funct7b5 = funct7b5; assign bl.funct7b5 = funct7b5;
  assign bf.Zero = Zero;         assign bl.Zero = Zero;
  assign bf.LessThan = LessThan; assign bl.LessThan = LessThan;
  assign bf.LessThanU = LessThanU; assign bl.LessThanU = LessThanU;
  assign bf.MemReady = MemReady; assign bl.MemReady = MemReady;

  riscv_multicycle_controller #(.FULL_ISA(1'b1), .MEM_WAIT(1'b1)) dut_full (
    .clk(clk), .reset(reset), .bus(bf));
  riscv_multicycle_controller #(.FULL_ISA(1'b0), .MEM_WAIT(1'b1)) dut_legacy (
    .clk(clk), .reset(reset), .bus(bl));

  logic [18:0] out_f, out_l, act;
  assign out_f = {bf.PCWrite, bf.AdrSrc, bf.MemWrite, bf.IRWrite, bf.RegWrite, bf.IllegalInstr,
                  bf.ResultSrc, bf.ALUSrcA, bf.ALUSrcB, bf.ALUControl, bf.ImmSrc};
  assign out_l = {bl.PCWrite, bl.AdrSrc, bl.MemWrite, bl.IRWrite, bl.RegWrite, bl.IllegalInstr,
                  bl.ResultSrc, bl.ALUSrcA, bl.ALUSrcB, bl.ALUControl, bl.ImmSrc};
  assign act = sel ? out_l : out_f;

  function automatic void chk(string name, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, a, e);
    end
  endfunction

  function automatic bit legal(logic [6:0] o, logic [2:0] f3, logic f7, bit full);
    bit base4;
    base4 = (f3 == 0) || (f3 == 2) || (f3 == 6) || (f3 == 7);
    case (o)
      LOAD, STORE, JAL: return 1'b1;
      RTYPE:  return full ? (!f7 || f3 == 0 || f3 == 5) : (base4 && (!f7 || f3 == 0));
      ITYPE:  return full ? !(f3 == 1 && f7) : base4;
      BRANCH: return full ? !(f3 == 2 || f3 == 3) : (f3 == 0);
      JALR, LUI, AUIPC: return full;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] model_alu(logic [2:0] f3, logic f7, bit is_r);
    case (f3)
      3'd0: return (is_r && f7) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7 ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic taken(logic [2:0] f3, logic z, logic lt, logic ltu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_for(logic [6:0] o);
    case (o)
      STORE: return 3'd1;
      BRANCH: return 3'd2;
      JAL: return 3'd3;
      LUI, AUIPC: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic exp_t exp_for(int p, bit mr, bit ill, logic [2:0] f3, logic f7,
                                   logic z, logic lt, logic ltu);
    exp_t e;
    e = '{default: '0};
    case (p)
      P_F:    begin e.c_adr = 1; e.c_sa = 1; e.sb = 2; e.c_sb = 1; e.c_alu = 1;
                    e.rs = 2; e.c_rs = 1; e.irw = mr; e.pcw = mr; end
      P_D:    begin e.sa = 1; e.sb = 1; e.c_sa = 1; e.c_sb = 1; e.c_alu = 1; e.ill = ill; end
      P_MA:   begin e.sa = 2; e.sb = 1; e.c_sa = 1; e.c_sb = 1; e.c_alu = 1; end
      P_MR:   begin e.adr = 1; e.c_adr = 1; end
      P_MWB:  begin e.rs = 1; e.c_rs = 1; e.regw = 1; end
      P_MW:   begin e.adr = 1; e.c_adr = 1; e.memw = mr; end
      P_XR:   begin e.sa = 2; e.sb = 0; e.c_sa = 1; e.c_sb = 1;
                    e.alu = model_alu(f3, f7, 1'b1); e.c_alu = 1; end
      P_XI:   begin e.sa = 2; e.sb = 1; e.c_sa = 1; e.c_sb = 1;
                    e.alu = model_alu(f3, f7, 1'b0); e.c_alu = 1; end
      P_LUI:  begin e.sb = 1; e.c_sb = 1; e.alu = 4'd10; e.c_alu = 1; end
      P_AUI:  begin e.sa = 1; e.sb = 1; e.c_sa = 1; e.c_sb = 1; e.c_alu = 1; end
      P_JALR: begin e.sa = 2; e.sb = 1; e.c_sa = 1; e.c_sb = 1; e.c_alu = 1; end
      P_JAL:  begin e.sa = 1; e.sb = 2; e.c_sa = 1; e.c_sb = 1; e.c_alu = 1;
                    e.c_rs = 1; e.pcw = 1; end
      P_WB:   begin e.c_rs = 1; e.regw = 1; end
      P_BR:   begin e.sa = 2; e.c_sa = 1; e.c_sb = 1; e.alu = 4'd1; e.c_alu = 1;
                    e.c_rs = 1; e.pcw = taken(f3, z, lt, ltu); end
      default: ;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("PCWrite", act[18], cur.pcw);
      chk("MemWrite", act[16], cur.memw);
      chk("IRWrite", act[15], cur.irw);
      chk("RegWrite", act[14], cur.regw);
      chk("IllegalInstr", act[13], cur.ill);
      chk("ImmSrc", act[2:0], cur.imm);
      if (cur.c_adr) chk("AdrSrc", act[17], cur.adr);
      if (cur.c_rs)  chk("ResultSrc", act[12:11], cur.rs);
      if (cur.c_sa)  chk("ALUSrcA", act[10:9], cur.sa);
      if (cur.c_sb)  chk("ALUSrcB", act[8:7], cur.sb);
      if (cur.c_alu) chk("ALUControl", act[6:3], cur.alu);
    end
  end

  task automatic do_reset();
    repeat (2) begin
      @(posedge clk); #1;
      reset = 1'b1;
      MemReady = 1'($urandom);
      cur = exp_for(P_RST, 0, 0, '0, 0, 0, 0, 0);
      cur.imm = imm_for(op);
      chk_en = 1'b1;
    end
  endtask

  // One instruction: the step list follows from its class; wait steps repeat
  // while MemReady is low, and abort_at injects reset on that cycle index.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input logic lt, input logic ltu, input bit full,
                           input int fw, input int mw, input int abort_at, output int cycles);
    int ph[$];
    int idx, waits, cyc, budget;
    bit ill, mr, wait_ph;
    ill = !legal(o, f3, f7, full);
    if (ill) ph = '{P_F, P_D};
    else case (o)
      LOAD:   ph = '{P_F, P_D, P_MA, P_MR, P_MWB};
      STORE:  ph = '{P_F, P_D, P_MA, P_MW};
      RTYPE:  ph = '{P_F, P_D, P_XR, P_WB};
      ITYPE:  ph = '{P_F, P_D, P_XI, P_WB};
      LUI:    ph = '{P_F, P_D, P_LUI, P_WB};
      AUIPC:  ph = '{P_F, P_D, P_AUI, P_WB};
      JAL:    ph = '{P_F, P_D, P_JAL, P_WB};
      JALR:   ph = '{P_F, P_D, P_JALR, P_JAL, P_WB};
      default: ph = '{P_F, P_D, P_BR};
    endcase
    idx = 0; waits = 0; cyc = 0;
    while (idx < ph.size()) begin
      @(posedge clk); #1;
      op = o; funct3 = f3; funct7b5 = f7; Zero = z; LessThan = lt; LessThanU = ltu;
      reset = 1'b0;
      if (cyc == abort_at) begin
        reset = 1'b1;
        MemReady = 1'b1;
        cur = exp_for(P_RST, 0, 0, f3, f7, z, lt, ltu);
        cur.imm = imm_for(o);
        chk_en = 1'b1;
        cyc++;
        break;
      end
      wait_ph = (ph[idx] == P_F) || (ph[idx] == P_MR) || (ph[idx] == P_MW);
      budget = (ph[idx] == P_F) ? fw : mw;
      mr = wait_ph ? (waits >= budget) : 1'($urandom);
      MemReady = mr;
      cur = exp_for(ph[idx], mr, ill, f3, f7, z, lt, ltu);
      cur.imm = imm_for(o);
      chk_en = 1'b1;
      if (wait_ph && !mr) waits++;
      else begin idx++; waits = 0; end
      cyc++;
    end
    cycles = cyc;
  endtask

  task automatic run_random(input bit full, input int count);
    logic [6:0] ops [11];
    int n, ab;
    ops = '{LOAD, STORE, RTYPE, ITYPE, JAL, JALR, BRANCH, LUI, AUIPC, 7'h00, 7'h7f};
    repeat (count) begin
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_instr(ops[$urandom_range(0, 10)], 3'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), full, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), ab, n);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    sel = 1'b0;
    do_reset();
    run_instr(RTYPE, 3'b000, 0, 0, 0, 0, 1, 0, 0, -1, n);  chk("cycles_r_add", n, 4);
    run_instr(LOAD, 3'b010, 0, 0, 0, 0, 1, 0, 2, -1, n);   chk("cycles_lw_wait2", n, 7);
    run_instr(BRANCH, 3'b001, 0, 0, 0, 0, 1, 0, 0, -1, n); chk("cycles_bne", n, 3);
    run_instr(BRANCH, 3'b111, 0, 0, 0, 1, 1, 0, 0, -1, n); chk("cycles_bgeu", n, 3);
    run_instr(JALR, 3'b000, 0, 0, 0, 0, 1, 0, 0, -1, n);   chk("cycles_jalr", n, 5);
    run_instr(JAL, 3'b000, 0, 0, 0, 0, 1, 0, 0, -1, n);    chk("cycles_jal", n, 4);
    run_instr(STORE, 3'b010, 0, 0, 0, 0, 1, 1, 0, -1, n);  chk("cycles_sw_fetchwait", n, 5);
    run_instr(STORE, 3'b010, 0, 0, 0, 0, 1, 0, 0, 3, n);   chk("cycles_sw_reset", n, 4);
    run_instr(RTYPE, 3'b001, 1, 0, 0, 0, 1, 0, 0, -1, n);  chk("cycles_r_illegal", n, 2);
    run_random(1'b1, 250);

    sel = 1'b1;
    do_reset();
    run_instr(LUI, 3'b000, 0, 0, 0, 0, 0, 0, 0, -1, n);    chk("cycles_legacy_lui", n, 2);
    run_instr(ITYPE, 3'b010, 1, 0, 0, 0, 0, 0, 0, -1, n);  chk("cycles_legacy_slti", n, 4);
    run_random(1'b0, 200);

    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
